// File: rtl/keypad_scanner.sv
// 4x4 key matrix scanner: rotates a one-hot row drive, debounces whole-pass
// results and hands each accepted key to the consumer with a Valid/Ack handshake.
module keypad_scanner #(
    parameter int DIV      = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    output logic [0:3] o_row,
    input  logic [0:3] i_col,
    output logic [0:3] o_key,
    output logic       o_valid,
    input  logic       i_ack,
    output logic       o_overrun
);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {S_SCAN, S_DEB, S_REL} state_t;

    logic [0:3]    r_col_s1, r_col_s2;
    logic [DW-1:0] r_div;
    logic [1:0]    r_ridx;
    logic [0:3]    r_row;
    logic [0:15]   r_rec;
    logic [0:3]    r_key;
    logic          r_valid, r_ovr;
    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt, r_rel, w_rel_nxt;
    logic [3:0]    r_cand, w_cand_nxt;

    logic          w_tick, w_close, w_single, w_none, w_accept;
    logic [0:15]   w_pass;
    logic [4:0]    w_ones;
    logic [3:0]    w_code;

    assign w_tick  = (r_div == DW'(DIV - 1));
    assign w_close = w_tick && (r_ridx == 2'd3);

    // The row being closed is taken straight from the synchronizer so the
    // pass result is available in the same cycle as its closing tick.
    always_comb begin
        w_pass = r_rec;
        w_pass[r_ridx*4 +: 4] = r_col_s2;
        w_ones = '0;
        w_code = '0;
        for (int i = 0; i < 16; i++) begin
            if (w_pass[i]) begin
                w_ones = w_ones + 5'd1;
                w_code = 4'(i);
            end
        end
    end

    assign w_single = (w_ones == 5'd1);
    assign w_none   = (w_ones == 5'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rel_nxt   = r_rel;
        w_cand_nxt  = r_cand;
        w_accept    = 1'b0;
        if (w_close) begin
            case (r_state)
                S_SCAN: begin
                    if (w_single) begin
                        w_cand_nxt = w_code;
                        if (DEBOUNCE == 1) begin
                            w_accept    = 1'b1;
                            w_state_nxt = S_REL;
                            w_cnt_nxt   = '0;
                            w_rel_nxt   = '0;
                        end else begin
                            w_cnt_nxt   = CW'(1);
                            w_state_nxt = S_DEB;
                        end
                    end
                end
                S_DEB: begin
                    if (w_single && (w_code == r_cand)) begin
                        if (r_cnt == CW'(DEBOUNCE - 1)) begin
                            w_accept    = 1'b1;
                            w_state_nxt = S_REL;
                            w_cnt_nxt   = '0;
                            w_rel_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + CW'(1);
                        end
                    end else begin
                        w_state_nxt = S_SCAN;
                        w_cnt_nxt   = '0;
                    end
                end
                S_REL: begin
                    if (!w_none) begin
                        w_rel_nxt = '0;
                    end else if (r_rel == CW'(DEBOUNCE - 1)) begin
                        w_state_nxt = S_SCAN;
                        w_rel_nxt   = '0;
                    end else begin
                        w_rel_nxt = r_rel + CW'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_SCAN;
                    w_cnt_nxt   = '0;
                    w_rel_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_SCAN;
            r_cnt   <= '0;
            r_rel   <= '0;
            r_cand  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rel   <= w_rel_nxt;
            r_cand  <= w_cand_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_col_s1 <= '0;
            r_col_s2 <= '0;
            r_div    <= '0;
            r_ridx   <= '0;
            r_row    <= 4'b1000;
            r_rec    <= '0;
            r_key    <= '0;
            r_valid  <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_col_s1 <= i_col;
            r_col_s2 <= r_col_s1;
            r_div    <= w_tick ? '0 : r_div + DW'(1);
            if (w_tick) begin
                r_rec[r_ridx*4 +: 4] <= r_col_s2;
                r_ridx <= r_ridx + 2'd1;
                r_row  <= {r_row[3], r_row[0:2]};
            end
            // Overrun can only be set while Valid is up, so a plain AND suffices.
            if (w_accept) begin
                r_key   <= w_code;
                r_valid <= 1'b1;
                r_ovr   <= r_valid & ~i_ack;
            end else if (i_ack && r_valid) begin
                r_valid <= 1'b0;
                r_ovr   <= 1'b0;
            end
        end
    end

    assign o_row     = r_row;
    assign o_key     = r_key;
    assign o_valid   = r_valid;
    assign o_overrun = r_ovr;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: pass-level behavioural model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_keypad_scanner;
    localparam int DIV = 4;
    localparam int DEB = 2;

    logic        clk, rst, ack;
    logic [15:0] pressed;
    logic [0:3]  w_col, o_row, o_key;
    logic        o_valid, o_overrun;
    int          cyc;
    int          n_vec, n_bad;
    bit          started;

    keypad_scanner #(.DIV(DIV), .DEBOUNCE(DEB)) dut (
        .i_clk(clk), .i_rst(rst), .o_row(o_row), .i_col(w_col),
        .o_key(o_key), .o_valid(o_valid), .i_ack(ack), .o_overrun(o_overrun)
    );

    always #5 clk = ~clk;

    // Key matrix: a pressed key shorts its row drive onto its column.
    always_comb begin
        w_col = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (o_row[r] && pressed[r*4+c]) w_col[c] = 1'b1;
    end

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Model: row slot phase, synchronizer delay, pass record and debounce rules.
    int         m_ph, m_ri, m_run, m_quiet, m_cand;
    bit         m_armed;
    logic [3:0] m_s1, m_s2, exp_key;
    logic [15:0] m_rec;
    logic       exp_valid, exp_ovr;

    always @(posedge clk) begin : model
        logic [3:0]  pins, key;
        logic [15:0] rec;
        int          n, code, run, quiet, cand;
        bit          armed, acc, tick;
        logic        vld, ovr;
        rec = m_rec; run = m_run; quiet = m_quiet; cand = m_cand; armed = m_armed;
        vld = exp_valid; ovr = exp_ovr; key = exp_key; acc = 0;
        if (rst) begin
            m_ph <= 0; m_ri <= 0; m_s1 <= '0; m_s2 <= '0; m_rec <= '0;
            m_run <= 0; m_quiet <= 0; m_cand <= 0; m_armed <= 1;
            exp_key <= '0; exp_valid <= 1'b0; exp_ovr <= 1'b0;
        end else begin
            for (int c = 0; c < 4; c++) pins[c] = pressed[m_ri*4+c];
            tick = (m_ph == DIV-1);
            if (tick) begin
                for (int c = 0; c < 4; c++) rec[m_ri*4+c] = m_s2[c];
                if (m_ri == 3) begin
                    n = 0; code = 0;
                    for (int i = 0; i < 16; i++) if (rec[i]) begin n++; code = i; end
                    if (!armed) begin
                        if (n == 0) begin
                            quiet++;
                            if (quiet == DEB) begin armed = 1; quiet = 0; end
                        end else quiet = 0;
                    end else if (run == 0) begin
                        if (n == 1) begin cand = code; run = 1; end
                    end else if (n == 1 && code == cand) begin
                        run++;
                    end else begin
                        run = 0;
                    end
                    if (armed && run == DEB) begin acc = 1; run = 0; armed = 0; quiet = 0; end
                end
            end
            if (acc) begin
                ovr = (vld && !ack) ? 1'b1 : (vld ? 1'b0 : ovr);
                vld = 1'b1;
                key = 4'(cand);
            end else if (ack && vld) begin
                vld = 1'b0; ovr = 1'b0;
            end
            m_rec <= rec; m_run <= run; m_quiet <= quiet; m_cand <= cand; m_armed <= armed;
            exp_key <= key; exp_valid <= vld; exp_ovr <= ovr;
            m_s2 <= m_s1; m_s1 <= pins;
            m_ph <= (m_ph + 1) % DIV;
            m_ri <= tick ? (m_ri + 1) % 4 : m_ri;
        end
    end

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cyc %0d)", nm, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            logic [3:0] er;
            er = 4'b1000 >> m_ri;
            chk("model row", o_row, er);
            chk("model key", o_key, exp_key);
            chk("model valid", {3'b0, o_valid}, {3'b0, exp_valid});
            chk("model overrun", {3'b0, o_overrun}, {3'b0, exp_ovr});
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) begin
            n_vec++; n_bad++;
            $display("FAIL wait_cyc: reached %0d, expected %0d", cyc, n);
        end
    endtask

    task automatic press(input int code);
        pressed = '0;
        pressed[code] = 1'b1;
    endtask

    task automatic chk_out(input string nm, input logic [3:0] k, input logic v, input logic o);
        chk({nm, " key"}, o_key, k);
        chk({nm, " valid"}, {3'b0, o_valid}, {3'b0, v});
        chk({nm, " overrun"}, {3'b0, o_overrun}, {3'b0, o});
    endtask

    initial begin
        clk = 0; rst = 1; ack = 0; pressed = '0; n_vec = 0; n_bad = 0; started = 0;
        repeat (2) @(posedge clk);

        // Idle rotation
        do_reset();
        started = 1;
        chk("idle row0", o_row, 4'b1000);
        chk_out("reset", 4'h0, 1'b0, 1'b0);
        wait_cyc(4);  chk("idle row1", o_row, 4'b0100);
        wait_cyc(8);  chk("idle row2", o_row, 4'b0010);
        wait_cyc(12); chk("idle row3", o_row, 4'b0001);
        wait_cyc(16); chk("idle wrap", o_row, 4'b1000);
        wait_cyc(40); chk_out("idle", 4'h0, 1'b0, 1'b0);

        // Held key 9: reported once after two passes
        press(9); do_reset();
        wait_cyc(31);  chk("k9 early valid", {3'b0, o_valid}, 4'h0);
        wait_cyc(32);  chk_out("k9 accept", 4'h9, 1'b1, 1'b0);
        wait_cyc(132); chk_out("k9 hold", 4'h9, 1'b1, 1'b0);
        ack = 1'b1;
        wait_cyc(133); ack = 1'b0;
        chk("k9 ack valid", {3'b0, o_valid}, 4'h0);
        wait_cyc(200); chk("k9 no repeat", {3'b0, o_valid}, 4'h0);
        pressed = '0;

        // Bounce: key 6 for one pass only, then key 9 proves SCAN again
        press(6); do_reset();
        wait_cyc(16); pressed = '0;
        wait_cyc(64); chk("bounce valid", {3'b0, o_valid}, 4'h0);
        press(9);
        wait_cyc(96); chk_out("after bounce", 4'h9, 1'b1, 1'b0);
        pressed = '0;

        // Keys 0 and 15 together, then 15 released
        pressed = '0; pressed[0] = 1'b1; pressed[15] = 1'b1; do_reset();
        wait_cyc(48); press(0);
        wait_cyc(79); chk("multi early valid", {3'b0, o_valid}, 4'h0);
        wait_cyc(80); chk_out("multi accept", 4'h0, 1'b1, 1'b0);
        pressed = '0;

        // Overrun: key 5 then key 10 without Ack
        press(5); do_reset();
        wait_cyc(32); chk_out("ovr k5", 4'h5, 1'b1, 1'b0);
        pressed = '0;
        wait_cyc(64); press(10);
        wait_cyc(95); chk_out("ovr pre", 4'h5, 1'b1, 1'b0);
        wait_cyc(96); chk_out("ovr k10", 4'hA, 1'b1, 1'b1);
        ack = 1'b1;
        wait_cyc(97); ack = 1'b0;
        chk_out("ovr ack", 4'hA, 1'b0, 1'b0);
        pressed = '0;

        // Accept coinciding with Ack
        press(5); do_reset();
        wait_cyc(32); pressed = '0;
        wait_cyc(64); press(10);
        wait_cyc(95); ack = 1'b1;
        wait_cyc(96); ack = 1'b0;
        chk_out("coincide", 4'hA, 1'b1, 1'b0);
        pressed = '0;

        // Reset mid-debounce of key 3
        press(3); do_reset();
        wait_cyc(20);
        do_reset();
        chk("mid reset row", o_row, 4'b1000);
        chk_out("mid reset", 4'h0, 1'b0, 1'b0);
        wait_cyc(31); chk("k3 early valid", {3'b0, o_valid}, 4'h0);
        wait_cyc(32); chk_out("k3 accept", 4'h3, 1'b1, 1'b0);
        pressed = '0;

        @(negedge clk);
        started = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Input-side counterpart of the multiplexed seven-segment output scanner. It drives one row of a 4x4 key matrix at a time, samples the columns and debounces across whole scan passes. Each accepted key press is presented as a 4-bit code with a Valid/Ack handshake to the CPU's I/O logic. It sits beside the display scanner on the board-I/O boundary and uses the same row-rotation cadence.

## Interface
- DIV, default 50000: clocks per row slot; benches use DIV=4; legal minimum 4.
- DEBOUNCE, default 4: consecutive identical full-pass results needed to accept a press or confirm a release; legal minimum 1.
- Clock  input  1  system clock; everything is on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- ROW  output  [0:3]  one-hot, active-high row drive; bit 0 is row 0.
- COL  input  [0:3]  asynchronous, active-high column sense (1 = pressed in the driven row); bit 0 is column 0.
- Key  output  [0:3]  accepted key code = row*4 + column.
- Valid  output  1  Key holds an unconsumed press.
- Ack  input  1  consumer strobe; acts only while Valid=1.
- Overrun  output  1  a press was accepted while Valid was still set.

## Operation
- COL passes through a 2-flop synchronizer. All decisions use the synchronized value.
- A divider counts 0..DIV-1. Tick is high for the one cycle where the count equals DIV-1.
- On tick:
  - The synchronized COL is recorded for the current row.
  - ROW rotates to the next row (1000→0100→0010→0001→1000); the new value is registered on the next edge.
  - The tick on row 3 closes a pass.
- Pass result is one of:
  - NONE: no bits set in any row.
  - SINGLE(c): exactly one bit set; c = row*4 + column.
  - MULTI: two or more bits set.
- State machine, evaluated only at pass close:
  - SCAN: SINGLE(c) → cand=c, cnt=1, go to DEBOUNCE. If DEBOUNCE=1, accept immediately and go to RELEASE. Anything else stays in SCAN.
  - DEBOUNCE: SINGLE(cand) → cnt+1; when cnt reaches DEBOUNCE, accept and go to RELEASE. Any other result → SCAN, cnt=0.
  - RELEASE: NONE → rel+1; when rel reaches DEBOUNCE, go to SCAN. Any key seen → rel=0. A held key is reported exactly once.
- Accept action:
  - Key ← cand, Valid ← 1.
  - If Valid was already 1 and Ack is not high in the same cycle, Overrun ← 1. The newest code wins.
- Ack with Valid=1: Valid ← 0 and Overrun ← 0 on the next edge. Ack with Valid=0 is ignored.
- Accept and Ack in the same cycle: the new Key is loaded, Valid stays 1, Overrun is not set.
- MULTI is never reported. The press is reported once the extra keys are released and the remaining single key debounces.

## Timing
- Reset values, effective on the edge where Reset=1:
  - Outputs: ROW=1000, Key=0000, Valid=0, Overrun=0.
  - Internal: state SCAN, divider 0, cnt=0, rel=0, pass record cleared, synchronizer flops cleared.
- Reset mid-pass or mid-debounce discards all partial state. Nothing is reported from before reset.
- First tick occurs DIV clocks after Reset falls. ROW changes on the cycle after each tick. Each row is held for DIV cycles.
- Sampled COL reflects the pins 2 cycles before the tick. DIV≥4 guarantees the sample belongs to the currently driven row.
- One pass lasts 4*DIV clocks.
- Latency: Valid rises on the edge following the pass-close tick of the DEBOUNCE-th consecutive matching pass.
- Valid holds indefinitely until Ack is sampled.
- Key, Valid and Overrun are registered outputs. ROW is registered.

## Test plan
All scenarios use DIV=4, DEBOUNCE=2, and a key model that drives COL from the current ROW.
- Reset, then idle:
  - ROW = 1000, 0100, 0010, 0001, 1000 in 4-clock steps.
  - Valid=0, Key=0, Overrun=0 throughout.
- Hold key at row2/col1 (COL=0100 while ROW=0010):
  - Key=9 and Valid=1 after the 2nd full pass.
  - Valid stays 1 for 100 clocks while the key is held.
  - One-cycle Ack → Valid=0 next cycle. No second report while held.
- Bounce: key 6 present for one pass, then absent → Valid never rises. The FSM returns to SCAN.
- Keys 0 and 15 held together → no Valid. Release key 15 → Key=0, Valid=1 after 2 passes.
- Overrun sequence:
  - Press key 5 → Valid=1.
  - Release for 2 passes, then press key 10 without Ack → Key=10, Valid=1, Overrun=1.
  - Ack → Valid=0 and Overrun=0.
  - Separately, accept coinciding with Ack → Valid=1, Overrun=0.
- Reset for one cycle mid-debounce of key 3:
  - All outputs return to reset values; ROW=1000.
  - Key 3 is reported only after 2 fresh passes following reset.
